// File: rtl/jam_cost_table_if.sv
// rtl/jam_cost_table_if.sv - load/lookup bus for the jam_cost_table cost-matrix store (reload port under JAM_COST_RELOAD_EN)
interface jam_cost_table_if #(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 7,
  parameter int SUM_W  = 13
);
  logic                 load_valid;
  logic [DATA_W-1:0]    load_data;
  logic                 load_ready;
  logic                 table_ready;
  logic [IDX_W-1:0]     W;
  logic [IDX_W-1:0]     J;
  logic [DATA_W-1:0]    Cost;
  logic [2*IDX_W:0]     load_count;
  logic [SUM_W-1:0]     checksum;
`ifdef JAM_COST_RELOAD_EN
  logic                 reload;
`endif

  // Driver side: the loader / search engine
  modport master (
    output load_valid, load_data, W, J,
`ifdef JAM_COST_RELOAD_EN
    output reload,
`endif
    input  load_ready, table_ready, Cost, load_count, checksum
  );

  // Cost-table side
  modport slave (
    input  load_valid, load_data, W, J,
`ifdef JAM_COST_RELOAD_EN
    input  reload,
`endif
    output load_ready, table_ready, Cost, load_count, checksum
  );
endinterface

// File: rtl/jam_cost_table.sv
// rtl/jam_cost_table.sv - N x N worker/job cost matrix: streaming load, registered lookup (optional reload via JAM_COST_RELOAD_EN)
module jam_cost_table #(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 7,
  parameter int SUM_W  = 13
) (
  input  logic             CLK,
  input  logic             RST,
  jam_cost_table_if.slave  bus
);
  localparam int N     = 1 << IDX_W;
  localparam int DEPTH = N * N;
  localparam int CNT_W = 2 * IDX_W + 1;

  typedef enum logic {ST_LOAD, ST_SERVE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
  logic [CNT_W-1:0]    r_load_count;
  logic [SUM_W-1:0]    r_checksum;
  logic [DATA_W-1:0]   r_cost;
  logic                w_accept;
  logic                w_last_entry;
  logic                w_reload;

  assign w_accept     = bus.load_valid && (r_state == ST_LOAD);
  assign w_last_entry = (r_load_count == CNT_W'(DEPTH - 1));
`ifdef JAM_COST_RELOAD_EN
  assign w_reload     = bus.reload && (r_state == ST_SERVE);
`else
  assign w_reload     = 1'b0;
`endif

  // State register; reset always lands in LOAD
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_LOAD;
    else     r_state <= w_next_state;
  end

  // Next state: leave LOAD on the edge that takes the last entry; reload returns to LOAD
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD:  if (w_accept && w_last_entry) w_next_state = ST_SERVE;
      ST_SERVE: if (w_reload)                 w_next_state = ST_LOAD;
      default:  w_next_state = ST_LOAD;
    endcase
  end

  // Progress counter and checksum, cleared by reset or by a reload request
  always_ff @(posedge CLK) begin
    if (RST || w_reload) begin
      r_load_count <= '0;
      r_checksum   <= '0;
    end else if (w_accept) begin
      r_load_count <= r_load_count + CNT_W'(1);
      r_checksum   <= r_checksum + {{(SUM_W-DATA_W){1'b0}}, bus.load_data};
    end
  end

  // Matrix storage, written row-major at the current count; contents survive reset
  always_ff @(posedge CLK) begin
    if (!RST && w_accept) r_mem[r_load_count[CNT_W-2:0]] <= bus.load_data;
  end

  // Lookup register: one-cycle latency in SERVE, held at zero while loading
  always_ff @(posedge CLK) begin
    if (RST)                      r_cost <= '0;
    else if (r_state == ST_SERVE) r_cost <= r_mem[{bus.W, bus.J}];
    else                          r_cost <= '0;
  end

  assign bus.load_ready  = (r_state == ST_LOAD);
  assign bus.table_ready = (r_state == ST_SERVE);
  assign bus.Cost        = r_cost;
  assign bus.load_count  = r_load_count;
  assign bus.checksum    = r_checksum;
endmodule

// File: tb/tb_jam_cost_table.sv
// tb/tb_jam_cost_table.sv - directed self-checking bench for jam_cost_table
module tb_jam_cost_table;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [6:0] exp_mem [0:63];
  int   exp_sum;

  jam_cost_table_if #(.IDX_W(3), .DATA_W(7), .SUM_W(13)) bus ();

  jam_cost_table #(.IDX_W(3), .DATA_W(7), .SUM_W(13)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Full 64-entry load; value(idx) = (idx*mul+add)%128; optional valid toggling 1,0,1,0
  task automatic load_full(input int mul, input int add, input bit toggle);
    int cnt = 0;
    int cyc = 0;
    logic [6:0] d;
    bit v;
    exp_sum = 0;
    while (cnt < 64 && cyc < 200) begin
      v = !(toggle && (cyc % 2 == 1));
      d = 7'((cnt * mul + add) % 128);
      bus.load_valid = v;
      bus.load_data  = v ? d : 7'd127;
      bus.W = 3'(cyc);
      bus.J = 3'(cyc + 3);
      chk("load_ready_in_load", 32'(bus.load_ready), 32'd1);
      chk("table_ready_in_load", 32'(bus.table_ready), 32'd0);
      tick();
      if (v) begin
        exp_mem[cnt] = d;
        exp_sum += int'(d);
        cnt++;
      end
      chk("load_count", 32'(bus.load_count), 32'(cnt));
      chk("cost_zero_in_load", 32'(bus.Cost), 32'd0);
      cyc++;
    end
    bus.load_valid = 1'b0;
    chk("table_ready_after_load", 32'(bus.table_ready), 32'd1);
    chk("load_ready_after_load", 32'(bus.load_ready), 32'd0);
    chk("load_count_full", 32'(bus.load_count), 32'd64);
    chk("checksum_after_load", 32'(bus.checksum), 32'(exp_sum));
  endtask

  // Sweep every W/J once; optionally push junk load entries that must be ignored
  task automatic sweep(input bit junk);
    chk("cost_first_serve", 32'(bus.Cost), 32'd0);
    for (int k = 0; k < 64; k++) begin
      bus.W = 3'(k >> 3);
      bus.J = 3'(k & 7);
      bus.load_valid = junk;
      bus.load_data  = 7'd127;
      tick();
      chk("cost_lookup", 32'(bus.Cost), 32'(exp_mem[k]));
    end
    bus.load_valid = 1'b0;
    chk("load_count_hold_serve", 32'(bus.load_count), 32'd64);
    chk("checksum_hold_serve", 32'(bus.checksum), 32'(exp_sum));
    chk("table_ready_hold_serve", 32'(bus.table_ready), 32'd1);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.W          = '0;
    bus.J          = '0;
`ifdef JAM_COST_RELOAD_EN
    bus.reload     = 1'b0;
`endif

    // Reset state
    RST = 1'b1;
    tick();
    tick();
    chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
    chk("rst_table_ready", 32'(bus.table_ready), 32'd0);
    chk("rst_cost", 32'(bus.Cost), 32'd0);
    chk("rst_load_count", 32'(bus.load_count), 32'd0);
    chk("rst_checksum", 32'(bus.checksum), 32'd0);
    RST = 1'b0;

    // Continuous load of (idx*5)%128, then full sweep with ignored load traffic
    load_full(5, 0, 1'b0);
    chk("checksum_idx5", 32'(bus.checksum), 32'd3680);
    chk("mem29_model", 32'(exp_mem[29]), 32'd17);
    sweep(1'b1);

    // Targeted lookup W=3,J=5 -> 17
    bus.W = 3'd3;
    bus.J = 3'd5;
    tick();
    chk("cost_w3_j5", 32'(bus.Cost), 32'd17);

    // Reset after 20 accepted entries, with load_valid still asserted alongside RST
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 7'(100 - i);
      tick();
    end
    chk("partial_count", 32'(bus.load_count), 32'd20);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.load_valid = 1'b0;
    chk("midrst_load_count", 32'(bus.load_count), 32'd0);
    chk("midrst_checksum", 32'(bus.checksum), 32'd0);
    chk("midrst_cost", 32'(bus.Cost), 32'd0);
    chk("midrst_table_ready", 32'(bus.table_ready), 32'd0);
    chk("midrst_load_ready", 32'(bus.load_ready), 32'd1);

    // Fresh load with load_valid toggling, then serve the new values
    load_full(3, 7, 1'b1);
    sweep(1'b0);

`ifdef JAM_COST_RELOAD_EN
    // Reload in SERVE while looking up W=0,J=0: old entry still returned
    bus.W = '0;
    bus.J = '0;
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    chk("reload_cost_old", 32'(bus.Cost), 32'(exp_mem[0]));
    chk("reload_table_ready", 32'(bus.table_ready), 32'd0);
    chk("reload_load_count", 32'(bus.load_count), 32'd0);
    chk("reload_checksum", 32'(bus.checksum), 32'd0);
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    chk("reload_ignored_in_load", 32'(bus.load_ready), 32'd1);
    load_full(0, 1, 1'b0);
    chk("reload_checksum_ones", 32'(bus.checksum), 32'd64);
    sweep(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
